// File: rtl/square_freq_meter.sv
// rtl/square_freq_meter.sv - gated rising-edge frequency counter with edge-to-edge period measurement
module square_freq_meter #(
    parameter int unsigned GATE_CYCLES = 1000000,
    parameter int unsigned COUNT_W     = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               square_in,
    input  logic               enable,
    output logic [COUNT_W-1:0] freq_count,
    output logic               overflow,
    output logic               valid,
    output logic [COUNT_W-1:0] period_cycles,
    output logic               period_valid
);
    localparam int unsigned        GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GATE,
        ST_LATCH
    } state_t;

    logic               sync_meta;
    logic               sync_q;
    logic               sync_dly;
    logic               edge_pulse;

    state_t             state;
    logic [GATE_W-1:0]  gate_cnt;
    logic [COUNT_W-1:0] edge_cnt;
    logic               ovf_flag;
    logic [COUNT_W-1:0] edge_next;
    logic               ovf_next;

    logic [COUNT_W-1:0] period_cnt;
    logic               armed;

    // square_in is asynchronous: two flops for metastability, a third for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            sync_dly  <= 1'b0;
        end else begin
            sync_meta <= square_in;
            sync_q    <= sync_meta;
            sync_dly  <= sync_q;
        end
    end

    assign edge_pulse = sync_q & ~sync_dly;

    always_comb begin
        edge_next = edge_cnt;
        ovf_next  = ovf_flag;
        if (edge_pulse) begin
            if (edge_cnt == CNT_MAX) begin
                ovf_next = 1'b1;
            end else begin
                edge_next = edge_cnt + CNT_ONE;
            end
        end
    end

    // Result registers load from the *next* edge count so a pulse on the last gate cycle is included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf_flag   <= 1'b0;
            freq_count <= '0;
            overflow   <= 1'b0;
            valid      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    ovf_flag <= 1'b0;
                    valid    <= 1'b0;
                    if (enable) begin
                        state <= ST_GATE;
                    end
                end
                ST_GATE: begin
                    if (!enable) begin
                        state    <= ST_IDLE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf_flag <= 1'b0;
                    end else begin
                        edge_cnt <= edge_next;
                        ovf_flag <= ovf_next;
                        if (gate_cnt == GATE_LAST) begin
                            state      <= ST_LATCH;
                            freq_count <= edge_next;
                            overflow   <= ovf_next;
                            valid      <= 1'b1;
                        end else begin
                            gate_cnt <= gate_cnt + GATE_W'(1);
                        end
                    end
                end
                ST_LATCH: begin
                    valid    <= 1'b0;
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    ovf_flag <= 1'b0;
                    state    <= enable ? ST_GATE : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    // Period counter runs free between edges; first edge after enable only arms the measurement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt    <= '0;
            armed         <= 1'b0;
            period_cycles <= '0;
            period_valid  <= 1'b0;
        end else if (!enable) begin
            period_cnt <= '0;
            armed      <= 1'b0;
        end else if (edge_pulse) begin
            if (armed) begin
                period_cycles <= (period_cnt == CNT_MAX) ? CNT_MAX : period_cnt + CNT_ONE;
                period_valid  <= 1'b1;
            end
            period_cnt <= '0;
            armed      <= 1'b1;
        end else if (period_cnt != CNT_MAX) begin
            period_cnt <= period_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_square_freq_meter.sv
// tb/tb_square_freq_meter.sv - scoreboard bench for square_freq_meter at COUNT_W 16 and 4
module tb_square_freq_meter;
    localparam int G     = 100;
    localparam int MAX16 = 65535;
    localparam int MAX4  = 15;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        square_in = 1'b0;
    logic        enable    = 1'b0;
    logic [15:0] fc16, pc16;
    logic        ov16, v16, pv16;
    logic [3:0]  fc4, pc4;
    logic        ov4, v4, pv4;

    always #5 clk = ~clk;

    square_freq_meter #(.GATE_CYCLES(G), .COUNT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .square_in(square_in), .enable(enable),
        .freq_count(fc16), .overflow(ov16), .valid(v16),
        .period_cycles(pc16), .period_valid(pv16)
    );

    square_freq_meter #(.GATE_CYCLES(G), .COUNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .square_in(square_in), .enable(enable),
        .freq_count(fc4), .overflow(ov4), .valid(v4),
        .period_cycles(pc4), .period_valid(pv4)
    );

    typedef struct {
        int at;
        int cnt;
        int per;
        bit pv;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];
    exp_t e16, e4;
    int   checks = 0;
    int   errors = 0;

    // reference model state: cycle label, pending pulse cycles, window and period bookkeeping
    int   cyc        = 0;
    int   pend[$];
    int   gate_first = -1;
    int   latch_at   = -1;
    int   last_p     = -1;
    int   wcnt       = 0;
    int   per        = 0;
    bit   pv         = 1'b0;
    bit   en_q       = 1'b0;
    bit   sq         = 1'b0;
    int   ph         = 0;

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_posedge(input int c);
        exp_t e;
        bit   pulse;
        pulse = 1'b0;
        while (pend.size() > 0 && pend[0] < c) void'(pend.pop_front());
        if (pend.size() > 0 && pend[0] == c) begin
            pulse = 1'b1;
            void'(pend.pop_front());
        end
        if (!en_q) begin
            last_p = -1;
        end else if (pulse) begin
            if (last_p >= 0) begin
                per = c - last_p;
                pv  = 1'b1;
            end
            last_p = c;
        end
        if (!en_q) begin
            gate_first = -1;
            latch_at   = -1;
        end else if (latch_at == c) begin
            gate_first = c + 1;
            wcnt       = 0;
            latch_at   = -1;
        end else if (latch_at < 0 && gate_first < 0) begin
            gate_first = c + 1;
            wcnt       = 0;
        end else if (gate_first >= 0 && c >= gate_first) begin
            if (pulse) wcnt++;
            if (c == gate_first + G - 1) begin
                e.at  = c;
                e.cnt = wcnt;
                e.per = per;
                e.pv  = pv;
                q16.push_back(e);
                q4.push_back(e);
                latch_at   = c + 1;
                gate_first = -1;
            end
        end
    endtask

    task automatic step(input bit en, input int period);
        bit nsq;
        @(posedge clk);
        cyc++;
        #1;
        if (rst_n) model_posedge(cyc);
        if (period == 0) begin
            nsq = 1'b0;
        end else begin
            nsq = (ph < period / 2);
            ph  = (ph + 1) % period;
        end
        if (nsq && !sq) pend.push_back(cyc + 3);
        sq        = nsq;
        square_in = nsq;
        enable    = en;
        en_q      = en;
    endtask

    task automatic run(input int n, input bit en, input int period);
        ph = 0;
        for (int i = 0; i < n; i++) step(en, period);
    endtask

    task automatic check_reset_outputs();
        check("rst_freq16", fc16, 0);
        check("rst_ovf16", ov16, 0);
        check("rst_valid16", v16, 0);
        check("rst_period16", pc16, 0);
        check("rst_pvalid16", pv16, 0);
        check("rst_freq4", fc4, 0);
        check("rst_ovf4", ov4, 0);
        check("rst_valid4", v4, 0);
        check("rst_period4", pc4, 0);
        check("rst_pvalid4", pv4, 0);
    endtask

    task automatic mid_reset();
        step(1'b1, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        pend.delete();
        gate_first = -1;
        latch_at   = -1;
        last_p     = -1;
        wcnt       = 0;
        per        = 0;
        pv         = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 0);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && v16) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valid16_unexpected actual=1 required=0 cycle=%0d", cyc);
            end else begin
                e16 = q16.pop_front();
                check("valid_cycle16", cyc, e16.at);
                check("freq16", fc16, sat(e16.cnt, MAX16));
                check("ovf16", ov16, e16.cnt > MAX16);
                check("period16", pc16, sat(e16.per, MAX16));
                check("pvalid16", pv16, e16.pv);
            end
        end
        if (rst_n && v4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valid4_unexpected actual=1 required=0 cycle=%0d", cyc);
            end else begin
                e4 = q4.pop_front();
                check("valid_cycle4", cyc, e4.at);
                check("freq4", fc4, sat(e4.cnt, MAX4));
                check("ovf4", ov4, e4.cnt > MAX4);
                check("period4", pc4, sat(e4.per, MAX4));
                check("pvalid4", pv4, e4.pv);
            end
        end
    end

    initial begin
        int len, prd;
        bit en;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        for (int i = 0; i < 3; i++) step(1'b0, 0);
        rst_n = 1'b1;

        run(205, 1'b1, 0);
        run(303, 1'b1, 10);
        run(202, 1'b1, 2);
        run(202, 1'b1, 20);

        run(3, 1'b0, 0);
        run(151, 1'b1, 10);
        run(10, 1'b0, 10);
        run(230, 1'b1, 10);

        run(3, 1'b0, 0);
        run(60, 1'b1, 7);
        mid_reset();
        run(250, 1'b1, 7);

        for (int s = 0; s < 14; s++) begin
            len = $urandom_range(250, 20);
            prd = ($urandom_range(5, 0) == 0) ? 0 : $urandom_range(40, 2);
            en  = ($urandom_range(5, 0) != 0);
            run(len, en, prd);
        end

        run(5, 1'b0, 0);
        check("pending16", q16.size(), 0);
        check("pending4", q4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=%0d required=finish", cyc);
        $fatal(1);
    end

endmodule

// File: doc/square_freq_meter.md
SQUARE_FREQ_METER -- requirements
Module: square_freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 1000000, gate window length in clk cycles (1 s at 1 MHz clk); legal range 2..2^24.
REQ-002 Parameter COUNT_W, default 20, width of edge and period counters; legal range 4..32.
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 square_in  input  1  square wave from the VCO, asynchronous to clk.
REQ-006 enable  input  1  1 = run back-to-back gate windows; 0 = idle/abort.
REQ-007 freq_count  output  COUNT_W  rising edges counted in the last completed window.
REQ-008 overflow  output  1  edge count saturated in the last completed window.
REQ-009 valid  output  1  one-cycle pulse, new freq_count/overflow available.
REQ-010 period_cycles  output  COUNT_W  clk cycles between the two most recent square_in rising edges.
REQ-011 period_valid  output  1  period_cycles holds a measured value.

Function
REQ-012 square_in SHALL pass through a 2-flop synchronizer, then a 1-flop delay; edge pulse = sync & ~delayed, asserted 3 clk after an input rising edge setup.
REQ-013 FSM states SHALL be IDLE, GATE, LATCH.
REQ-014 IDLE: gate and edge counters held at 0; enable=1 -> GATE next cycle.
REQ-015 GATE: gate counter increments every cycle; edge counter increments on each edge pulse, including the pulse on the final gate cycle.
REQ-016 Edge counter SHALL saturate at 2^COUNT_W-1; an edge arriving at saturation sets an internal overflow flag.
REQ-017 GATE with gate counter == GATE_CYCLES-1 and enable=1 -> LATCH.
REQ-018 On LATCH entry freq_count <= edge count, overflow <= flag; valid SHALL be 1 exactly while in LATCH (one cycle).
REQ-019 LATCH -> GATE with counters and flag cleared if enable=1, else -> IDLE; an edge pulse during LATCH is not counted (one-cycle dead time).
REQ-020 enable=0 in GATE -> IDLE next cycle, no valid, freq_count/overflow retain prior values.
REQ-021 Period counter SHALL increment every cycle while enable=1, saturating at 2^COUNT_W-1.
REQ-022 On edge pulse: if armed, period_cycles <= period counter + 1 (saturating), period_valid <= 1; always counter <= 0 and armed <= 1.
REQ-023 enable=0 SHALL clear armed and the period counter; period_cycles/period_valid hold.
REQ-024 Without edges period_cycles holds; saturated value all-ones marks a too-slow input.
REQ-025 Measurable input range: 1 edge per window up to clk/2 (input period >= 2 clk cycles, each level >= 1 clk).

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE and clear synchronizer, delay flop, all counters, armed, overflow flag.
REQ-027 During reset freq_count=0, overflow=0, valid=0, period_cycles=0, period_valid=0.
REQ-028 Reset mid-GATE SHALL discard the partial window; after release with enable=1 the first full window starts the cycle after IDLE.

Verification (GATE_CYCLES=100, COUNT_W=16 unless stated)
REQ-029 enable=1, square_in period 10 clk -> each valid: freq_count=10, overflow=0; period_cycles=10, period_valid=1 after second edge.
REQ-030 square_in toggling every clk (period 2) -> freq_count=50 each window, period_cycles=2.
REQ-031 square_in constant 0 -> valid every 101 clk with freq_count=0; period_valid stays 0.
REQ-032 COUNT_W=4, square_in period 2 -> freq_count=15, overflow=1; next window with period 20 -> freq_count=5, overflow=0.
REQ-033 enable dropped at gate cycle 50 of second window -> no valid, freq_count keeps first-window value; re-enable -> full window, correct count.
REQ-034 rst_n pulsed low mid-GATE -> all outputs 0 asynchronously; after release, first valid only after a complete 100-cycle window.
